// File: rtl/result_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : result_classifier                                             |
// | Purpose  : Scans the per-class result registers after a calculation and  |
// |            reports the signed argmax, the winning score and, when the    |
// |            CLASSIFIER_MARGIN_EN macro is defined, the saturated top-two  |
// |            margin, all qualified by a sticky valid flag.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module result_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              overflow_in,
  output logic [SEL_W-1:0]  out_sel,
  input  logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [SEL_W-1:0]  class_id,
  output logic [DATA_W-1:0] max_value,
  output logic [DATA_W-1:0] margin,
  output logic              overflow_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_CLASSES - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   best_q, best_d;
  logic [SEL_W-1:0]    best_idx_q, best_idx_d;
  logic [SEL_W-1:0]    class_id_q, class_id_d;
  logic [DATA_W-1:0]   max_value_q, max_value_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

`ifdef CLASSIFIER_MARGIN_EN
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0]   second_q, second_d;
  logic [DATA_W-1:0]   margin_q, margin_d;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   margin_sat;

  // Sign-extended difference; best never falls below second so the result is
  // non-negative, and anything above the largest positive word is clamped.
  always_comb begin
    diff       = {best_q[DATA_W-1], best_q} - {second_q[DATA_W-1], second_q};
    margin_sat = (diff[DATA_W:DATA_W-1] != 2'b00) ? MOST_POS : diff[DATA_W-1:0];
  end
`endif

  // Next-state and datapath update for the IDLE / SCAN / FINAL sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_id_d  = class_id_q;
    max_value_d = max_value_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
`ifdef CLASSIFIER_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          idx_d      = '0;
          best_d     = MOST_NEG;
          best_idx_d = '0;
          valid_d    = 1'b0;
          ovf_d      = overflow_in;
`ifdef CLASSIFIER_MARGIN_EN
          second_d   = MOST_NEG;
`endif
        end
      end
      SCAN: begin
        // Strict compare keeps the lower index on ties.
        if ($signed(out_data) > $signed(best_q)) begin
          best_d     = out_data;
          best_idx_d = idx_q;
`ifdef CLASSIFIER_MARGIN_EN
          second_d   = best_q;
        end else if ($signed(out_data) > $signed(second_q)) begin
          second_d   = out_data;
`endif
        end
        if (idx_q == LAST_IDX) begin
          state_d = FINAL;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      FINAL: begin
        max_value_d = best_q;
        class_id_d  = best_idx_q;
        valid_d     = 1'b1;
        done_d      = 1'b1;
        state_d     = IDLE;
`ifdef CLASSIFIER_MARGIN_EN
        margin_d    = margin_sat;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      best_q      <= MOST_NEG;
      best_idx_q  <= '0;
      class_id_q  <= '0;
      max_value_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_id_q  <= class_id_d;
      max_value_q <= max_value_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef CLASSIFIER_MARGIN_EN
  // Second-best tracker and published margin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      second_q <= MOST_NEG;
      margin_q <= '0;
    end else begin
      second_q <= second_d;
      margin_q <= margin_d;
    end
  end

  assign margin = margin_q;
`else
  assign margin = '0;
`endif

  assign out_sel      = (state_q == SCAN) ? idx_q : '0;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign valid        = valid_q;
  assign class_id     = class_id_q;
  assign max_value    = max_value_q;
  assign overflow_out = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_result_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_result_classifier                                          |
// | Purpose  : Directed self-checking bench for result_classifier.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_result_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        overflow_in;
  logic [3:0]  out_sel;
  logic [31:0] out_data;
  logic        busy, done, valid, overflow_out;
  logic [3:0]  class_id;
  logic [31:0] max_value, margin;

  logic [31:0] mem [16];
  int tests  = 0;
  int failed = 0;
  int lat, ndone;

  result_classifier dut (
    .clk(clk), .rst(rst), .start(start), .overflow_in(overflow_in),
    .out_sel(out_sel), .out_data(out_data), .busy(busy), .done(done),
    .valid(valid), .class_id(class_id), .max_value(max_value),
    .margin(margin), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  // Result-register file model: combinational read.
  always_comb out_data = mem[out_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_margin(input logic [31:0] m);
`ifdef CLASSIFIER_MARGIN_EN
    return m;
`else
    return 32'd0 & m;
`endif
  endfunction

  task automatic load(input logic [31:0] v [10]);
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? v[i] : 32'hDEAD_BEEF;
  endtask

  // Pulse start, optionally re-pulse it at cycle 'again', count done pulses.
  task automatic run_scan(input logic ovf, input int again, output int l, output int n);
    @(negedge clk);
    start = 1'b1;
    overflow_in = ovf;
    @(posedge clk);
    #1;
    start = 1'b0;
    overflow_in = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("valid_cleared", {31'd0, valid}, 32'd0);
    l = -1;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == again);
      @(posedge clk);
      #1;
      if (done) begin
        n++;
        if (l < 0) l = c;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] cid,
                              input logic [31:0] mx, input logic [31:0] mg);
    check({tag, "_latency"}, lat, 32'd11);
    check({tag, "_ndone"}, ndone, 32'd1);
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_class"}, {28'd0, class_id}, {28'd0, cid});
    check({tag, "_max"}, max_value, mx);
    check({tag, "_margin"}, margin, exp_margin(mg));
  endtask

  logic [31:0] v_basic [10] = '{5, 3, 9, 1, 0, 2, 8, 7, 4, 6};
  logic [31:0] v_neg   [10] = '{-10, -3, -7, -12, -15, -9, -8, -11, -5, -20};
  logic [31:0] v_tie   [10] = '{0, 4, 4, 1, 2, 3, 0, 1, 2, 3};
  logic [31:0] v_sat   [10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'h8000_0000};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    overflow_in = 1'b0;
    load(v_basic);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_sel", {28'd0, out_sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_class", {28'd0, class_id}, 32'd0);
    check("rst_max", max_value, 32'd0);
    check("rst_margin", margin, 32'd0);
    check("rst_ovf", {31'd0, overflow_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_scan(1'b0, 0, lat, ndone);
    check_result("basic", 4'd2, 32'd9, 32'd1);
    check("basic_ovf", {31'd0, overflow_out}, 32'd0);

    load(v_neg);
    run_scan(1'b0, 0, lat, ndone);
    check_result("neg", 4'd1, 32'hFFFF_FFFD, 32'd2);

    load(v_tie);
    run_scan(1'b0, 0, lat, ndone);
    check_result("tie", 4'd1, 32'd4, 32'd0);

    load(v_sat);
    run_scan(1'b0, 0, lat, ndone);
    check_result("sat", 4'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // Second start three cycles into the scan must be ignored.
    load(v_basic);
    run_scan(1'b0, 3, lat, ndone);
    check_result("ignore", 4'd2, 32'd9, 32'd1);

    // Reset in the middle of a scan (idx=5).
    load(v_neg);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_out_sel", {28'd0, out_sel}, 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_class", {28'd0, class_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check("mid_rst_quiet", ndone, 32'd0);

    load(v_basic);
    run_scan(1'b1, 0, lat, ndone);
    check_result("after_rst", 4'd2, 32'd9, 32'd1);
    check("after_rst_ovf", {31'd0, overflow_out}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
